// File: rtl/challengeqsys_block_copier.sv
// Avalon-MM master that copies a block of words within a dual-port on-chip memory,
// one word per read/capture/write triple, keeping a running checksum of the data read.
module challengeqsys_block_copier #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     src,
    input  logic [ADDR_W-1:0]     dst,
    input  logic [ADDR_W-1:0]     len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     words_done,
    output logic [DATA_W-1:0]     checksum,
    output logic [ADDR_W-1:0]     address,
    output logic                  chipselect,
    output logic                  write,
    output logic [DATA_W/8-1:0]   byteenable,
    output logic [DATA_W-1:0]     writedata,
    input  logic [DATA_W-1:0]     readdata
);

    typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, DONE} state_t;

    localparam logic [DATA_W/8-1:0] BE_ALL = '1;

    state_t              state;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [ADDR_W-1:0]   len_q;
    logic [ADDR_W-1:0]   idx;
    logic                abort_flag;
    logic [ADDR_W-1:0]   idx_next;

    assign idx_next = idx + ADDR_W'(1);

    // Bus outputs are registered: each transition loads the values for the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            idx        <= '0;
            abort_flag <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            words_done <= '0;
            checksum   <= '0;
            address    <= '0;
            chipselect <= 1'b0;
            write      <= 1'b0;
            byteenable <= '0;
            writedata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    abort_flag <= 1'b0;
                    if (start) begin
                        src_q      <= src;
                        dst_q      <= dst;
                        len_q      <= len;
                        idx        <= '0;
                        words_done <= '0;
                        checksum   <= '0;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= READ;
                            busy       <= 1'b1;
                            chipselect <= 1'b1;
                            write      <= 1'b0;
                            address    <= src;
                        end
                    end
                end
                READ: begin
                    if (abort) abort_flag <= 1'b1;
                    state      <= CAPT;
                    chipselect <= 1'b0;
                    address    <= '0;
                end
                CAPT: begin
                    if (abort) abort_flag <= 1'b1;
                    // writedata doubles as the data register holding the word in flight
                    writedata  <= readdata;
                    checksum   <= checksum + readdata;
                    state      <= WRITE;
                    chipselect <= 1'b1;
                    write      <= 1'b1;
                    address    <= dst_q + idx;
                    byteenable <= BE_ALL;
                end
                WRITE: begin
                    idx        <= idx_next;
                    words_done <= words_done + ADDR_W'(1);
                    write      <= 1'b0;
                    writedata  <= '0;
                    byteenable <= '0;
                    if (idx_next == len_q || abort_flag || abort) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        chipselect <= 1'b0;
                        address    <= '0;
                    end else begin
                        state      <= READ;
                        chipselect <= 1'b1;
                        address    <= src_q + idx_next;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
